// File: rtl/snn_pkg.sv
// Shared widths and defaults for the spiking layers (LIF spike source, MAC consumer).
// Also holds the accumulator width rule used by saturating membrane updates.
package snn_pkg;

    localparam int unsigned SNN_N          = 5;
    localparam int unsigned SNN_WIDTH      = 8;
    localparam int unsigned SNN_MEM_W      = 12;
    localparam int unsigned SNN_VTH        = 100;
    localparam int unsigned SNN_LEAK_SHIFT = 3;
    localparam int unsigned SNN_REFRAC     = 2;
    localparam int unsigned SNN_T_STEPS    = 4;
    localparam int unsigned SNN_REFR_W     = 4;

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_e;

    // One guard bit above the wider operand is enough to detect overflow of a two-term add.
    function automatic int unsigned acc_width(input int unsigned mem_w, input int unsigned sum_w);
        return ((mem_w > sum_w) ? mem_w : sum_w) + 1;
    endfunction

endpackage

// File: rtl/lif_spike_layer_if.sv
// Input-sum and output-spike handshake bundle for lif_spike_layer.
interface lif_spike_layer_if #(
    parameter int unsigned N     = 5,
    parameter int unsigned WIDTH = 8
) ();

    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] sums;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       spikes;
    logic               frame_done;

    modport master (
        output in_valid, sums, out_ready,
        input  in_ready, out_valid, spikes, frame_done
    );

    modport slave (
        input  in_valid, sums, out_ready,
        output in_ready, out_valid, spikes, frame_done
    );

endinterface

// File: rtl/lif_spike_layer_neuron.sv
// Single leaky integrate-and-fire neuron: membrane, refractory counter and fire decision.
// spike_o is combinational from the current state and sum; state only moves when en_i is set.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int unsigned WIDTH      = SNN_WIDTH,
    parameter int unsigned MEM_W      = SNN_MEM_W,
    parameter int unsigned VTH        = SNN_VTH,
    parameter int unsigned LEAK_SHIFT = SNN_LEAK_SHIFT,
    parameter int unsigned REFRAC     = SNN_REFRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] sum_i,
    output logic             spike_o
);

    localparam int unsigned ACC_W = acc_width(MEM_W, WIDTH);

    logic [MEM_W-1:0]      v_q, v_d;
    logic [SNN_REFR_W-1:0] refr_q, refr_d;
    logic [MEM_W-1:0]      leak;
    logic [MEM_W-1:0]      v_leak;
    logic [ACC_W-1:0]      acc;
    logic [MEM_W-1:0]      v_sat;

    always_comb begin
        leak    = (LEAK_SHIFT != 0) ? (v_q >> LEAK_SHIFT) : '0;
        v_leak  = v_q - leak;
        acc     = ACC_W'(v_leak) + ACC_W'(sum_i);
        v_sat   = (acc[ACC_W-1:MEM_W] != '0) ? '1 : acc[MEM_W-1:0];
        spike_o = 1'b0;
        v_d     = v_q;
        refr_d  = refr_q;
        if (refr_q != '0) begin
            v_d    = '0;
            refr_d = refr_q - SNN_REFR_W'(1);
        end else if (v_sat >= MEM_W'(VTH)) begin
            spike_o = 1'b1;
            v_d     = '0;
            refr_d  = SNN_REFR_W'(REFRAC);
        end else begin
            v_d = v_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            v_q    <= '0;
            refr_q <= '0;
        end else if (en_i) begin
            v_q    <= v_d;
            refr_q <= refr_d;
        end
    end

endmodule

// File: rtl/lif_spike_layer.sv
// Bank of N LIF neurons with a one-entry registered spike output and a per-frame step counter.
module lif_spike_layer
    import snn_pkg::*;
#(
    parameter int unsigned N          = SNN_N,
    parameter int unsigned WIDTH      = SNN_WIDTH,
    parameter int unsigned MEM_W      = SNN_MEM_W,
    parameter int unsigned VTH        = SNN_VTH,
    parameter int unsigned LEAK_SHIFT = SNN_LEAK_SHIFT,
    parameter int unsigned REFRAC     = SNN_REFRAC,
    parameter int unsigned T_STEPS    = SNN_T_STEPS
) (
    input logic              clk,
    input logic              rst,
    input logic              clear,
    lif_spike_layer_if.slave bus
);

    localparam int unsigned STEP_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;

    out_state_e        state_q, state_d;
    logic [N-1:0]      spikes_q, spikes_d;
    logic [N-1:0]      spike_w;
    logic              done_q, done_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              accept;
    logic              last_step;
    logic              neuron_clr;

    assign bus.in_ready = (state_q == OUT_EMPTY) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !clear;
    assign last_step    = (step_q == STEP_W'(T_STEPS - 1));
    // Frame-boundary clear rides the same edge as the last accept; the spike is taken first.
    assign neuron_clr   = clear || (accept && last_step);

    for (genvar g = 0; g < N; g++) begin : g_neuron
        lif_neuron #(
            .WIDTH      (WIDTH),
            .MEM_W      (MEM_W),
            .VTH        (VTH),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRAC     (REFRAC)
        ) u_neuron (
            .clk     (clk),
            .rst     (rst),
            .clear_i (neuron_clr),
            .en_i    (accept),
            .sum_i   (bus.sums[g*WIDTH +: WIDTH]),
            .spike_o (spike_w[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        spikes_d = spikes_q;
        done_d   = done_q;
        step_d   = step_q;
        if (clear) begin
            state_d  = OUT_EMPTY;
            spikes_d = '0;
            done_d   = 1'b0;
            step_d   = '0;
        end else if (accept) begin
            state_d  = OUT_FULL;
            spikes_d = spike_w;
            done_d   = last_step;
            step_d   = last_step ? '0 : step_q + STEP_W'(1);
        end else if ((state_q == OUT_FULL) && bus.out_ready) begin
            state_d = OUT_EMPTY;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= OUT_EMPTY;
            spikes_q <= '0;
            done_q   <= 1'b0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            spikes_q <= spikes_d;
            done_q   <= done_d;
            step_q   <= step_d;
        end
    end

    assign bus.out_valid  = (state_q == OUT_FULL);
    assign bus.spikes     = spikes_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_lif_spike_layer.sv
// Directed bench for lif_spike_layer: three configurations share one stimulus stream.
module tb_lif_spike_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [39:0] sums;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    lif_spike_layer_if #(.N(5), .WIDTH(8)) ifa ();
    lif_spike_layer_if #(.N(5), .WIDTH(8)) ifb ();
    lif_spike_layer_if #(.N(5), .WIDTH(8)) ifc ();

    assign ifa.in_valid  = in_valid;
    assign ifa.sums      = sums;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.sums      = sums;
    assign ifb.out_ready = out_ready;
    assign ifc.in_valid  = in_valid;
    assign ifc.sums      = sums;
    assign ifc.out_ready = out_ready;

    // Default configuration: VTH=100, leak >>3, refractory 2, 4-step frames.
    lif_spike_layer #(
        .N(5), .WIDTH(8), .MEM_W(12), .VTH(100), .LEAK_SHIFT(3), .REFRAC(2), .T_STEPS(4)
    ) dut_a (.clk(clk), .rst(rst), .clear(clear), .bus(ifa));

    // Longer frames so the refractory sequence is not cut by a frame boundary.
    lif_spike_layer #(
        .N(5), .WIDTH(8), .MEM_W(12), .VTH(100), .LEAK_SHIFT(3), .REFRAC(2), .T_STEPS(8)
    ) dut_b (.clk(clk), .rst(rst), .clear(clear), .bus(ifb));

    // No leak, threshold at full scale, to exercise saturation.
    lif_spike_layer #(
        .N(5), .WIDTH(8), .MEM_W(12), .VTH(4095), .LEAK_SHIFT(0), .REFRAC(2), .T_STEPS(32)
    ) dut_c (.clk(clk), .rst(rst), .clear(clear), .bus(ifc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse();
        clear    = 1'b1;
        in_valid = 1'b0;
        tick();
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sums = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ifa.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", ifa.out_valid);
        end
        checks++;
        if (ifa.spikes !== 5'b00000) begin
            errors++; $display("FAIL reset_spikes: got %b expected 00000", ifa.spikes);
        end
        checks++;
        if (ifa.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", ifa.in_ready);
        end
        checks++;
        if (ifa.frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_frame_done: got %b expected 0", ifa.frame_done);
        end
    endtask

    task automatic test_integrate();
        logic [4:0] exp_sp;
        clear_pulse();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sums      = '0;
        sums[7:0] = 8'd60;
        for (int k = 1; k <= 2; k++) begin
            tick();
            exp_sp = (k == 2) ? 5'b00001 : 5'b00000;
            checks++;
            if (ifa.out_valid !== 1'b1) begin
                errors++; $display("FAIL integ_valid step%0d: got %b expected 1", k, ifa.out_valid);
            end
            checks++;
            if (ifa.spikes !== exp_sp) begin
                errors++; $display("FAIL integ_spikes step%0d: got %b expected %b", k, ifa.spikes, exp_sp);
            end
            checks++;
            if (ifa.frame_done !== 1'b0) begin
                errors++; $display("FAIL integ_done step%0d: got %b expected 0", k, ifa.frame_done);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (ifa.out_valid !== 1'b0) begin
            errors++; $display("FAIL integ_drain: got %b expected 0", ifa.out_valid);
        end
    endtask

    task automatic test_refractory();
        logic [4:0] exp_sp;
        clear_pulse();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        sums       = '0;
        sums[15:8] = 8'd255;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_sp = (k == 1 || k == 4) ? 5'b00010 : 5'b00000;
            checks++;
            if (ifb.spikes !== exp_sp) begin
                errors++; $display("FAIL refr_spikes step%0d: got %b expected %b", k, ifb.spikes, exp_sp);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        clear_pulse();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sums      = '0;
        sums[7:0] = 8'd50;
        tick();
        checks++;
        if (ifa.out_valid !== 1'b1 || ifa.spikes !== 5'b00000) begin
            errors++; $display("FAIL bp_first: got valid=%b spikes=%b expected valid=1 spikes=00000",
                               ifa.out_valid, ifa.spikes);
        end
        out_ready = 1'b0;
        sums[7:0] = 8'd60;
        #1;
        checks++;
        if (ifa.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready_comb: got %b expected 0", ifa.in_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (ifa.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready stall%0d: got %b expected 0", k, ifa.in_ready);
            end
            checks++;
            if (ifa.out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_valid stall%0d: got %b expected 1", k, ifa.out_valid);
            end
            checks++;
            if (ifa.spikes !== 5'b00000) begin
                errors++; $display("FAIL bp_spikes stall%0d: got %b expected 00000", k, ifa.spikes);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (ifa.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b expected 1", ifa.in_ready);
        end
        tick();
        checks++;
        if (ifa.spikes !== 5'b00001 || ifa.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release: got valid=%b spikes=%b expected valid=1 spikes=00001",
                               ifa.out_valid, ifa.spikes);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (ifa.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain: got %b expected 0", ifa.out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [4:0] exp_sp;
        clear_pulse();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sums      = '0;
        sums[7:0] = 8'd255;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_sp = (k == 17) ? 5'b00001 : 5'b00000;
            checks++;
            if (ifc.spikes !== exp_sp) begin
                errors++; $display("FAIL sat_spikes step%0d: got %b expected %b", k, ifc.spikes, exp_sp);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_frame_clear();
        logic exp_done;
        clear_pulse();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sums      = '0;
        sums[7:0] = 8'd25;
        // v0: 25, 47, 67, 84 -> never fires inside the frame
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_done = (k == 4);
            checks++;
            if (ifa.frame_done !== exp_done) begin
                errors++; $display("FAIL frame_done step%0d: got %b expected %b", k, ifa.frame_done, exp_done);
            end
            checks++;
            if (ifa.spikes !== 5'b00000) begin
                errors++; $display("FAIL frame_spikes step%0d: got %b expected 00000", k, ifa.spikes);
            end
        end
        // A membrane left at 84 would fire on 84-10+90; a cleared one reaches only 90.
        sums[7:0] = 8'd90;
        tick();
        checks++;
        if (ifa.spikes !== 5'b00000 || ifa.frame_done !== 1'b0) begin
            errors++; $display("FAIL frame_cleared_mem: got spikes=%b done=%b expected spikes=00000 done=0",
                               ifa.spikes, ifa.frame_done);
        end
        sums[7:0] = 8'd0;
        tick();
        checks++;
        if (ifa.spikes !== 5'b00000 || ifa.frame_done !== 1'b0) begin
            errors++; $display("FAIL frame_step2: got spikes=%b done=%b expected spikes=00000 done=0",
                               ifa.spikes, ifa.frame_done);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (ifa.out_valid !== 1'b0) begin
            errors++; $display("FAIL clear_out_valid: got %b expected 0", ifa.out_valid);
        end
        checks++;
        if (ifa.frame_done !== 1'b0) begin
            errors++; $display("FAIL clear_frame_done: got %b expected 0", ifa.frame_done);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_done = (k == 4);
            checks++;
            if (ifa.frame_done !== exp_done) begin
                errors++; $display("FAIL post_clear_done step%0d: got %b expected %b", k, ifa.frame_done, exp_done);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_integrate();
        test_refractory();
        test_backpressure();
        test_saturation();
        test_frame_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_spike_layer.md
Name: lif_spike_layer

Overview:
- Bank of N leaky integrate-and-fire neurons. Each timestep it takes one weighted sum per neuron from the upstream MAC array and produces one spike bit per neuron.
- The spike vector is the binary "pixels" input that feeds the next layer's MAC stage. This block is the spike source; the MAC is the spike consumer.
- Valid/ready handshake on both sides; a one-entry output register.

Parameters:
- N, 5, number of neurons (spike vector width)
- WIDTH, 8, width of each unsigned input sum
- MEM_W, 12, unsigned membrane potential width
- VTH, 100, firing threshold (MEM_W bits)
- LEAK_SHIFT, 3, leak = v >> LEAK_SHIFT; value 0 disables leak
- REFRAC, 2, refractory length in accepted timesteps (0..15)
- T_STEPS, 4, timesteps per frame (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous frame restart; clears all neuron state
- in_valid  in  1  sums valid for this timestep
- in_ready  out  1  block accepts sums this cycle
- sums  in  N*WIDTH  neuron i sum at [i*WIDTH +: WIDTH], unsigned
- out_valid  out  1  spike vector valid
- out_ready  in  1  downstream accepts spikes
- spikes  out  N  spike bit per neuron
- frame_done  out  1  high with out_valid on the last timestep of a frame

Behaviour:
- Reset values: out_valid=0, spikes=0, frame_done=0, all membranes=0, refractory counters=0, step counter=0.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Latency: a timestep accepted at edge k appears as out_valid/spikes/frame_done after edge k. Throughput is one timestep per cycle under continuous out_ready.
- Output hold: while out_valid && !out_ready, spikes and frame_done hold stable and no state changes. A handshake with no new accept clears out_valid.
- Per neuron i on accept:
  - Refractory (refr_i != 0): v_i stays 0, refr_i decrements, spike_i=0.
  - Otherwise: v_next = v_i - (LEAK_SHIFT ? v_i>>LEAK_SHIFT : 0) + sums_i. Compute this MEM_W+1 bits wide and saturate at 2^MEM_W-1.
  - If v_next >= VTH: spike_i=1, v_i=0, refr_i=REFRAC.
  - Else: spike_i=0, v_i=v_next.
- The leak uses the pre-update v. The threshold compare uses the saturated value.
- Step counter:
  - Increments on each accept.
  - When an accept occurs with counter == T_STEPS-1, frame_done=1 for that output, the counter wraps to 0, and all membranes and refractory counters clear (frame boundary).
  - frame_done=0 on all other outputs.
- clear has priority over accept. It zeroes membranes, refractory counters, step counter and out_valid, and drops any pending output. in_ready is still driven, but the sums are ignored that cycle.
- rst mid-frame behaves the same as clear, plus all outputs return to their reset values.
- No state changes when there is no accept and no clear.

Decomposition:
- Shared package snn_pkg: WIDTH, MEM_W, VTH, N and the saturating-add width rule, so mac_layer2 and this block share widths.
- One sub-module, lif_neuron: a single neuron holding membrane, refractory counter, leak/integrate/threshold logic, plus an enable and a clear input.
- Instantiate N copies of lif_neuron via generate. The top level owns the handshake, output register and step counter.

Test Plan:
- Reset, then idle -> out_valid=0, spikes=5'b0, in_ready=1, frame_done=0.
- Neuron0 sum=60 (others 0), two timesteps, out_ready=1 -> step1 spikes=0 (v=60). Step2 v=60-7+60=113 -> spikes=5'b00001, v0 reset to 0.
- Refractory: neuron1 sum=255 for 4 steps, T_STEPS=8 -> spikes[1] = 1,0,0,1 over steps 1-4.
- Backpressure: out_ready=0 after one accept, in_valid held with new sums for 3 cycles -> in_ready=0, spikes stable, no membrane change. out_ready=1 -> the next sums are accepted the same cycle.
- Saturation: VTH=4095, LEAK_SHIFT=0, sum=255 each step -> no spike for steps 1-16 (v=4080). Step 17 saturates to 4095 -> spike.
- Frame and clear:
  - T_STEPS=4, 4 accepts -> frame_done=1 only on output 4, membranes zero afterward.
  - Assert clear after step 2 of a new frame -> out_valid=0. The next frame's step 4 (not step 2) raises frame_done.
